// File: rtl/param_stack_unit_pkg.sv
// rtl/param_stack_unit_pkg.sv - shared processor encodings for the parameter stack
package param_stack_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP         = 3'b000;
    localparam logic [OP_W-1:0] OP_PUSH        = 3'b001;
    localparam logic [OP_W-1:0] OP_POP         = 3'b010;
    localparam logic [OP_W-1:0] OP_REPLACE     = 3'b011;
    localparam logic [OP_W-1:0] OP_POP_REPLACE = 3'b100;
    localparam logic [OP_W-1:0] OP_DUP         = 3'b101;
    localparam logic [OP_W-1:0] OP_SWAP        = 3'b110;
    localparam logic [OP_W-1:0] OP_DROP2       = 3'b111;

endpackage

// File: rtl/param_stack_unit_stack_ram.sv
// rtl/param_stack_unit_stack_ram.sv - DEPTH x WIDTH stack storage, two write and two async read ports
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Port B is only used by SWAP, whose two addresses never collide.
    always_ff @(posedge CLK) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/param_stack_unit.sv
// rtl/param_stack_unit.sv - parameterised hardware stack with count, bounds checks and sticky error flags
module param_stack_unit
    import param_stack_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovfl,
    output logic             unfl
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovfl_q, unfl_q, ovfl_set, unfl_set;
    logic             has1, has2, is_full;
    logic [AW-1:0]    top_addr, nos_addr, push_addr;
    logic [WIDTH-1:0] rd_top, rd_nos;
    logic             we_a, we_b;
    logic [AW-1:0]    wa_a, wa_b;
    logic [WIDTH-1:0] wd_a, wd_b;

    // Entry i lives at address i, so the count doubles as the push pointer.
    assign top_addr  = AW'(cnt_q - CW'(1));
    assign nos_addr  = AW'(cnt_q - CW'(2));
    assign push_addr = AW'(cnt_q);

    assign has1    = (cnt_q != '0);
    assign has2    = (cnt_q >= CW'(2));
    assign is_full = (cnt_q == CW'(DEPTH));

    always_comb begin
        cnt_d    = cnt_q;
        ovfl_set = 1'b0;
        unfl_set = 1'b0;
        we_a     = 1'b0;
        wa_a     = top_addr;
        wd_a     = din;
        we_b     = 1'b0;
        wa_b     = nos_addr;
        wd_b     = rd_top;
        case (op)
            OP_PUSH: begin
                if (is_full) ovfl_set = 1'b1;
                else begin
                    we_a  = 1'b1;
                    wa_a  = push_addr;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OP_POP: begin
                if (!has1) unfl_set = 1'b1;
                else cnt_d = cnt_q - CW'(1);
            end
            OP_REPLACE: begin
                if (!has1) unfl_set = 1'b1;
                else we_a = 1'b1;
            end
            OP_POP_REPLACE: begin
                if (!has2) unfl_set = 1'b1;
                else begin
                    we_a  = 1'b1;
                    wa_a  = nos_addr;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            OP_DUP: begin
                if (!has1) unfl_set = 1'b1;
                else if (is_full) ovfl_set = 1'b1;
                else begin
                    we_a  = 1'b1;
                    wa_a  = push_addr;
                    wd_a  = rd_top;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OP_SWAP: begin
                if (!has2) unfl_set = 1'b1;
                else begin
                    we_a = 1'b1;
                    wd_a = rd_nos;
                    we_b = 1'b1;
                end
            end
            OP_DROP2: begin
                if (!has2) unfl_set = 1'b1;
                else cnt_d = cnt_q - CW'(2);
            end
            default: ;
        endcase
    end

    // A new error wins over a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q  <= '0;
            ovfl_q <= 1'b0;
            unfl_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovfl_q <= (ovfl_q & ~clr_err) | ovfl_set;
            unfl_q <= (unfl_q & ~clr_err) | unfl_set;
        end
    end

    stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .CLK     (CLK),
        .we_a    (we_a & ~reset),
        .addr_a  (wa_a),
        .data_a  (wd_a),
        .we_b    (we_b & ~reset),
        .addr_b  (wa_b),
        .data_b  (wd_b),
        .raddr_a (top_addr),
        .rdata_a (rd_top),
        .raddr_b (nos_addr),
        .rdata_b (rd_nos)
    );

    assign tos   = has1 ? rd_top : '0;
    assign nos   = has2 ? rd_nos : '0;
    assign count = cnt_q;
    assign empty = ~has1;
    assign full  = is_full;
    assign ovfl  = ovfl_q;
    assign unfl  = unfl_q;

endmodule

// File: tb/tb_param_stack_unit.sv
// tb/tb_param_stack_unit.sv - directed bench for param_stack_unit at 8x4 and 32x256 with a per-cycle reference model
module tb_param_stack_unit;
    import param_stack_unit_pkg::*;

    logic        CLK;
    logic        reset;
    logic [2:0]  op;
    logic [31:0] din;
    logic        clr_err;

    logic [7:0]  tos0, nos0;
    logic [2:0]  count0;
    logic        empty0, full0, ovfl0, unfl0;
    logic [31:0] tos1, nos1;
    logic [8:0]  count1;
    logic        empty1, full1, ovfl1, unfl1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [2][256];
    int          mc [2];
    bit          mo [2];
    bit          mu [2];

    param_stack_unit #(.WIDTH(8), .DEPTH(4)) dut0 (
        .CLK(CLK), .reset(reset), .op(op), .din(din[7:0]), .clr_err(clr_err),
        .tos(tos0), .nos(nos0), .count(count0), .empty(empty0), .full(full0),
        .ovfl(ovfl0), .unfl(unfl0)
    );

    param_stack_unit #(.WIDTH(32), .DEPTH(256)) dut1 (
        .CLK(CLK), .reset(reset), .op(op), .din(din), .clr_err(clr_err),
        .tos(tos1), .nos(nos1), .count(count1), .empty(empty1), .full(full1),
        .ovfl(ovfl1), .unfl(unfl1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input int k, input int depth, input logic [31:0] mask,
                               input logic [2:0] o, input logic [31:0] d,
                               input logic c, input logic r);
        logic [31:0] t;
        if (r) begin
            mc[k] = 0; mo[k] = 0; mu[k] = 0;
            return;
        end
        if (c) begin
            mo[k] = 0; mu[k] = 0;
        end
        case (o)
            OP_PUSH:
                if (mc[k] < depth) begin mm[k][mc[k]] = d & mask; mc[k]++; end
                else mo[k] = 1;
            OP_POP:
                if (mc[k] >= 1) mc[k]--; else mu[k] = 1;
            OP_REPLACE:
                if (mc[k] >= 1) mm[k][mc[k]-1] = d & mask; else mu[k] = 1;
            OP_POP_REPLACE:
                if (mc[k] >= 2) begin mm[k][mc[k]-2] = d & mask; mc[k]--; end
                else mu[k] = 1;
            OP_DUP:
                if (mc[k] == 0) mu[k] = 1;
                else if (mc[k] == depth) mo[k] = 1;
                else begin mm[k][mc[k]] = mm[k][mc[k]-1]; mc[k]++; end
            OP_SWAP:
                if (mc[k] >= 2) begin
                    t = mm[k][mc[k]-1];
                    mm[k][mc[k]-1] = mm[k][mc[k]-2];
                    mm[k][mc[k]-2] = t;
                end else mu[k] = 1;
            OP_DROP2:
                if (mc[k] >= 2) mc[k] -= 2; else mu[k] = 1;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_tos(input int k);
        return (mc[k] > 0) ? mm[k][mc[k]-1] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_nos(input int k);
        return (mc[k] > 1) ? mm[k][mc[k]-2] : 32'h0;
    endfunction

    task automatic compare_all;
        check("m0_tos",   64'(tos0),   64'(exp_tos(0)));
        check("m0_nos",   64'(nos0),   64'(exp_nos(0)));
        check("m0_count", 64'(count0), 64'(mc[0]));
        check("m0_empty", 64'(empty0), 64'(mc[0] == 0));
        check("m0_full",  64'(full0),  64'(mc[0] == 4));
        check("m0_ovfl",  64'(ovfl0),  64'(mo[0]));
        check("m0_unfl",  64'(unfl0),  64'(mu[0]));
        check("m1_tos",   64'(tos1),   64'(exp_tos(1)));
        check("m1_nos",   64'(nos1),   64'(exp_nos(1)));
        check("m1_count", 64'(count1), 64'(mc[1]));
        check("m1_empty", 64'(empty1), 64'(mc[1] == 0));
        check("m1_full",  64'(full1),  64'(mc[1] == 256));
        check("m1_ovfl",  64'(ovfl1),  64'(mo[1]));
        check("m1_unfl",  64'(unfl1),  64'(mu[1]));
    endtask

    // Inputs change #1 after the edge; outputs are sampled #1 after the next edge.
    task automatic step(input logic [2:0] o, input logic [31:0] d, input logic c, input logic r);
        op = o; din = d; clr_err = c; reset = r;
        @(posedge CLK);
        #1;
        model_apply(0, 4,   32'h0000_00FF, o, d, c, r);
        model_apply(1, 256, 32'hFFFF_FFFF, o, d, c, r);
        compare_all();
        op = OP_NOP; din = '0; clr_err = 1'b0; reset = 1'b0;
    endtask

    initial begin
        op = OP_NOP; din = '0; clr_err = 1'b0; reset = 1'b1;
        for (int k = 0; k < 2; k++) begin mc[k] = 0; mo[k] = 0; mu[k] = 0; end

        // Reset state
        step(OP_PUSH, 32'h1, 1'b0, 1'b1);
        check("rst_count0", 64'(count0), 0);
        check("rst_empty0", 64'(empty0), 1);
        check("rst_full0",  64'(full0),  0);
        check("rst_tos0",   64'(tos0),   0);
        check("rst_nos1",   64'(nos1),   0);

        // PUSH 1, PUSH 2, POP_REPLACE 3
        step(OP_PUSH, 32'h1, 1'b0, 1'b0);
        step(OP_PUSH, 32'h2, 1'b0, 1'b0);
        check("pr_pre_nos1", 64'(nos1), 1);
        step(OP_POP_REPLACE, 32'h3, 1'b0, 1'b0);
        check("pr_tos0",   64'(tos0),   3);
        check("pr_count0", 64'(count0), 1);
        check("pr_nos0",   64'(nos0),   0);
        check("pr_flags0", 64'({ovfl0, unfl0}), 0);
        check("pr_tos1",   64'(tos1),   3);

        // PUSH AAAA, PUSH 5555, SWAP, DUP
        step(OP_NOP, 32'h0, 1'b0, 1'b1);
        step(OP_PUSH, 32'hAAAA, 1'b0, 1'b0);
        step(OP_PUSH, 32'h5555, 1'b0, 1'b0);
        step(OP_SWAP, 32'h0, 1'b0, 1'b0);
        check("sw_tos1",   64'(tos1),   32'hAAAA);
        check("sw_nos1",   64'(nos1),   32'h5555);
        check("sw_count1", 64'(count1), 2);
        check("sw_tos0",   64'(tos0),   8'hAA);
        check("sw_nos0",   64'(nos0),   8'h55);
        step(OP_DUP, 32'h0, 1'b0, 1'b0);
        check("dup_tos1",   64'(tos1),   32'hAAAA);
        check("dup_nos1",   64'(nos1),   32'hAAAA);
        check("dup_count1", 64'(count1), 3);
        step(OP_REPLACE, 32'h1234, 1'b0, 1'b0);
        check("rep_tos1", 64'(tos1), 32'h1234);
        check("rep_tos0", 64'(tos0), 8'h34);

        // Overflow at DEPTH=4
        step(OP_NOP, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step(OP_PUSH, 32'(i), 1'b0, 1'b0);
        check("ov_count0", 64'(count0), 4);
        check("ov_full0",  64'(full0),  1);
        check("ov_tos0",   64'(tos0),   4);
        check("ov_ovfl0",  64'(ovfl0),  1);
        check("ov_count1", 64'(count1), 5);
        check("ov_ovfl1",  64'(ovfl1),  0);
        step(OP_DUP, 32'h0, 1'b0, 1'b0);
        check("ovdup_count0", 64'(count0), 4);
        step(OP_POP, 32'h0, 1'b0, 1'b0);
        check("ovpop_count0", 64'(count0), 3);
        check("ovpop_tos0",   64'(tos0),   3);
        check("ovpop_ovfl0",  64'(ovfl0),  1);
        step(OP_NOP, 32'h0, 1'b1, 1'b0);
        check("ovclr_ovfl0", 64'(ovfl0), 0);

        // Underflow on empty, then DROP2 with one entry
        step(OP_NOP, 32'h0, 1'b0, 1'b1);
        step(OP_POP, 32'h0, 1'b0, 1'b0);
        check("un_unfl0",  64'(unfl0),  1);
        check("un_count0", 64'(count0), 0);
        step(OP_PUSH, 32'h7, 1'b0, 1'b0);
        step(OP_DROP2, 32'h0, 1'b0, 1'b0);
        check("d2_unfl1",  64'(unfl1),  1);
        check("d2_count1", 64'(count1), 1);
        check("d2_tos1",   64'(tos1),   7);
        step(OP_SWAP, 32'h0, 1'b0, 1'b0);
        check("sw1_tos0", 64'(tos0), 7);
        step(OP_NOP, 32'h0, 1'b1, 1'b0);
        check("clr_unfl1", 64'(unfl1), 0);
        check("clr_unfl0", 64'(unfl0), 0);
        step(OP_POP_REPLACE, 32'h9, 1'b0, 1'b0);
        check("pr1_unfl0", 64'(unfl0), 1);
        check("pr1_tos0",  64'(tos0),  7);

        // clr_err racing a new error, reset racing a PUSH
        step(OP_NOP, 32'h0, 1'b0, 1'b1);
        step(OP_POP, 32'h0, 1'b1, 1'b0);
        check("race_unfl0", 64'(unfl0), 1);
        step(OP_PUSH, 32'h9, 1'b0, 1'b1);
        check("rp_count1", 64'(count1), 0);
        check("rp_empty1", 64'(empty1), 1);
        check("rp_tos1",   64'(tos1),   0);
        check("rp_unfl0",  64'(unfl0),  0);
        step(OP_REPLACE, 32'h5, 1'b0, 1'b0);
        check("rp_rep_unfl1", 64'(unfl1), 1);
        step(OP_PUSH, 32'h4, 1'b1, 1'b0);
        check("rp_push_count1", 64'(count1), 1);
        check("rp_push_tos1",   64'(tos1),   4);
        check("rp_push_nos1",   64'(nos1),   0);

        // Fill the deep stack to its limit
        step(OP_NOP, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) step(OP_PUSH, 32'h100 + 32'(i), 1'b0, 1'b0);
        check("fill_full1",  64'(full1),  1);
        check("fill_count1", 64'(count1), 256);
        check("fill_tos1",   64'(tos1),   32'h1FF);
        check("fill_ovfl1",  64'(ovfl1),  0);
        step(OP_PUSH, 32'hDEAD, 1'b0, 1'b0);
        check("fill_ov_ovfl1",  64'(ovfl1),  1);
        check("fill_ov_count1", 64'(count1), 256);
        check("fill_ov_tos1",   64'(tos1),   32'h1FF);
        step(OP_SWAP, 32'h0, 1'b0, 1'b0);
        check("fill_sw_tos1", 64'(tos1), 32'h1FE);
        step(OP_DROP2, 32'h0, 1'b0, 1'b0);
        check("fill_d2_count1", 64'(count1), 254);
        check("fill_d2_tos1",   64'(tos1),   32'h1FD);
        for (int i = 0; i < 6; i++) step(OP_DROP2, 32'h0, 1'b0, 1'b0);
        step(OP_DUP, 32'h0, 1'b0, 1'b0);
        step(OP_POP_REPLACE, 32'hCAFE_F00D, 1'b0, 1'b0);
        check("fill_pr_tos1", 64'(tos1), 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
